// File: rtl/gamma_serial.sv
// gamma_serial: sequential Anubis gamma (nonlinear) layer for a 128-bit cipher state.
//
// A block is accepted into an internal byte register. LANES bytes are then
// substituted per clock through LANES S-box lanes until all 16 bytes are done.
// The result is held on out_data until downstream takes it. Only one block is
// in flight at a time.
//
// Parameters:
//   LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_data    state in; byte 0 = [127:120], byte 15 = [7:0]
//   in_valid   in_data valid
//   in_ready   block can be accepted (IDLE and not in reset)
//   out_data   substituted state, same byte order; zero unless out_valid
//   out_valid  out_data valid, held until out_ready
//   out_ready  downstream accepts out_data
//   busy       block being substituted or waiting for handoff
module gamma_serial #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned NCHUNK   = 16 / LANES;
    localparam int unsigned LANE_SH  = $clog2(LANES);
    localparam logic [3:0]  CNT_LAST = 4'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [7:0] st_q [16];
    logic       out_valid_q;
    logic       busy_q;

    logic [7:0] in_bytes  [16];
    logic [7:0] sub_bytes [16];
    logic [3:0] lane_idx  [LANES];
    logic [7:0] lane_out  [LANES];

    // Anubis 8-bit involutive S-box.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'ha7;  8'h01: s = 8'hd3;
            8'h02: s = 8'he6;  8'h03: s = 8'h71;
            8'h04: s = 8'hd0;  8'h05: s = 8'hac;
            8'h06: s = 8'h4d;  8'h07: s = 8'h79;
            8'h08: s = 8'h3a;  8'h09: s = 8'hc9;
            8'h0a: s = 8'h91;  8'h0b: s = 8'hfc;
            8'h0c: s = 8'h1e;  8'h0d: s = 8'h47;
            8'h0e: s = 8'h54;  8'h0f: s = 8'hbd;
            8'h10: s = 8'h8c;  8'h11: s = 8'ha5;
            8'h12: s = 8'h7a;  8'h13: s = 8'hfb;
            8'h14: s = 8'h63;  8'h15: s = 8'hb8;
            8'h16: s = 8'hdd;  8'h17: s = 8'hd4;
            8'h18: s = 8'he5;  8'h19: s = 8'hb3;
            8'h1a: s = 8'hc5;  8'h1b: s = 8'hbe;
            8'h1c: s = 8'ha9;  8'h1d: s = 8'h88;
            8'h1e: s = 8'h0c;  8'h1f: s = 8'ha2;
            8'h20: s = 8'h39;  8'h21: s = 8'hdf;
            8'h22: s = 8'h29;  8'h23: s = 8'hda;
            8'h24: s = 8'h2b;  8'h25: s = 8'ha8;
            8'h26: s = 8'hcb;  8'h27: s = 8'h4c;
            8'h28: s = 8'h4b;  8'h29: s = 8'h22;
            8'h2a: s = 8'haa;  8'h2b: s = 8'h24;
            8'h2c: s = 8'h41;  8'h2d: s = 8'h70;
            8'h2e: s = 8'ha6;  8'h2f: s = 8'hf9;
            8'h30: s = 8'h5a;  8'h31: s = 8'he2;
            8'h32: s = 8'hb0;  8'h33: s = 8'h36;
            8'h34: s = 8'h7d;  8'h35: s = 8'he4;
            8'h36: s = 8'h33;  8'h37: s = 8'hff;
            8'h38: s = 8'h60;  8'h39: s = 8'h20;
            8'h3a: s = 8'h08;  8'h3b: s = 8'h8b;
            8'h3c: s = 8'h5e;  8'h3d: s = 8'hab;
            8'h3e: s = 8'h7f;  8'h3f: s = 8'h78;
            8'h40: s = 8'h7c;  8'h41: s = 8'h2c;
            8'h42: s = 8'h57;  8'h43: s = 8'hd2;
            8'h44: s = 8'hdc;  8'h45: s = 8'h6d;
            8'h46: s = 8'h7e;  8'h47: s = 8'h0d;
            8'h48: s = 8'h53;  8'h49: s = 8'h94;
            8'h4a: s = 8'hc3;  8'h4b: s = 8'h28;
            8'h4c: s = 8'h27;  8'h4d: s = 8'h06;
            8'h4e: s = 8'h5f;  8'h4f: s = 8'had;
            8'h50: s = 8'h67;  8'h51: s = 8'h5c;
            8'h52: s = 8'h55;  8'h53: s = 8'h48;
            8'h54: s = 8'h0e;  8'h55: s = 8'h52;
            8'h56: s = 8'hea;  8'h57: s = 8'h42;
            8'h58: s = 8'h5b;  8'h59: s = 8'h5d;
            8'h5a: s = 8'h30;  8'h5b: s = 8'h58;
            8'h5c: s = 8'h51;  8'h5d: s = 8'h59;
            8'h5e: s = 8'h3c;  8'h5f: s = 8'h4e;
            8'h60: s = 8'h38;  8'h61: s = 8'h8a;
            8'h62: s = 8'h72;  8'h63: s = 8'h14;
            8'h64: s = 8'he7;  8'h65: s = 8'hc6;
            8'h66: s = 8'hde;  8'h67: s = 8'h50;
            8'h68: s = 8'h8e;  8'h69: s = 8'h92;
            8'h6a: s = 8'hd1;  8'h6b: s = 8'h77;
            8'h6c: s = 8'h93;  8'h6d: s = 8'h45;
            8'h6e: s = 8'h9a;  8'h6f: s = 8'hce;
            8'h70: s = 8'h2d;  8'h71: s = 8'h03;
            8'h72: s = 8'h62;  8'h73: s = 8'hb6;
            8'h74: s = 8'hb9;  8'h75: s = 8'hbf;
            8'h76: s = 8'h96;  8'h77: s = 8'h6b;
            8'h78: s = 8'h3f;  8'h79: s = 8'h07;
            8'h7a: s = 8'h12;  8'h7b: s = 8'hae;
            8'h7c: s = 8'h40;  8'h7d: s = 8'h34;
            8'h7e: s = 8'h46;  8'h7f: s = 8'h3e;
            8'h80: s = 8'hdb;  8'h81: s = 8'hcf;
            8'h82: s = 8'hec;  8'h83: s = 8'hcc;
            8'h84: s = 8'hc1;  8'h85: s = 8'ha1;
            8'h86: s = 8'hc0;  8'h87: s = 8'hd6;
            8'h88: s = 8'h1d;  8'h89: s = 8'hf4;
            8'h8a: s = 8'h61;  8'h8b: s = 8'h3b;
            8'h8c: s = 8'h10;  8'h8d: s = 8'hd8;
            8'h8e: s = 8'h68;  8'h8f: s = 8'ha0;
            8'h90: s = 8'hb1;  8'h91: s = 8'h0a;
            8'h92: s = 8'h69;  8'h93: s = 8'h6c;
            8'h94: s = 8'h49;  8'h95: s = 8'hfa;
            8'h96: s = 8'h76;  8'h97: s = 8'hc4;
            8'h98: s = 8'h9e;  8'h99: s = 8'h9b;
            8'h9a: s = 8'h6e;  8'h9b: s = 8'h99;
            8'h9c: s = 8'hc2;  8'h9d: s = 8'hb7;
            8'h9e: s = 8'h98;  8'h9f: s = 8'hbc;
            8'ha0: s = 8'h8f;  8'ha1: s = 8'h85;
            8'ha2: s = 8'h1f;  8'ha3: s = 8'hb4;
            8'ha4: s = 8'hf8;  8'ha5: s = 8'h11;
            8'ha6: s = 8'h2e;  8'ha7: s = 8'h00;
            8'ha8: s = 8'h25;  8'ha9: s = 8'h1c;
            8'haa: s = 8'h2a;  8'hab: s = 8'h3d;
            8'hac: s = 8'h05;  8'had: s = 8'h4f;
            8'hae: s = 8'h7b;  8'haf: s = 8'hb2;
            8'hb0: s = 8'h32;  8'hb1: s = 8'h90;
            8'hb2: s = 8'haf;  8'hb3: s = 8'h19;
            8'hb4: s = 8'ha3;  8'hb5: s = 8'hf7;
            8'hb6: s = 8'h73;  8'hb7: s = 8'h9d;
            8'hb8: s = 8'h15;  8'hb9: s = 8'h74;
            8'hba: s = 8'hee;  8'hbb: s = 8'hca;
            8'hbc: s = 8'h9f;  8'hbd: s = 8'h0f;
            8'hbe: s = 8'h1b;  8'hbf: s = 8'h75;
            8'hc0: s = 8'h86;  8'hc1: s = 8'h84;
            8'hc2: s = 8'h9c;  8'hc3: s = 8'h4a;
            8'hc4: s = 8'h97;  8'hc5: s = 8'h1a;
            8'hc6: s = 8'h65;  8'hc7: s = 8'hf6;
            8'hc8: s = 8'hed;  8'hc9: s = 8'h09;
            8'hca: s = 8'hbb;  8'hcb: s = 8'h26;
            8'hcc: s = 8'h83;  8'hcd: s = 8'heb;
            8'hce: s = 8'h6f;  8'hcf: s = 8'h81;
            8'hd0: s = 8'h04;  8'hd1: s = 8'h6a;
            8'hd2: s = 8'h43;  8'hd3: s = 8'h01;
            8'hd4: s = 8'h17;  8'hd5: s = 8'he1;
            8'hd6: s = 8'h87;  8'hd7: s = 8'hf5;
            8'hd8: s = 8'h8d;  8'hd9: s = 8'he3;
            8'hda: s = 8'h23;  8'hdb: s = 8'h80;
            8'hdc: s = 8'h44;  8'hdd: s = 8'h16;
            8'hde: s = 8'h66;  8'hdf: s = 8'h21;
            8'he0: s = 8'hfe;  8'he1: s = 8'hd5;
            8'he2: s = 8'h31;  8'he3: s = 8'hd9;
            8'he4: s = 8'h35;  8'he5: s = 8'h18;
            8'he6: s = 8'h02;  8'he7: s = 8'h64;
            8'he8: s = 8'hf2;  8'he9: s = 8'hf1;
            8'hea: s = 8'h56;  8'heb: s = 8'hcd;
            8'hec: s = 8'h82;  8'hed: s = 8'hc8;
            8'hee: s = 8'hba;  8'hef: s = 8'hf0;
            8'hf0: s = 8'hef;  8'hf1: s = 8'he9;
            8'hf2: s = 8'he8;  8'hf3: s = 8'hfd;
            8'hf4: s = 8'h89;  8'hf5: s = 8'hd7;
            8'hf6: s = 8'hc7;  8'hf7: s = 8'hb5;
            8'hf8: s = 8'ha4;  8'hf9: s = 8'h2f;
            8'hfa: s = 8'h95;  8'hfb: s = 8'h13;
            8'hfc: s = 8'h0b;  8'hfd: s = 8'hf3;
            8'hfe: s = 8'he0;  8'hff: s = 8'h37;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Byte b of the bus sits at [127-8b -: 8]; internally bytes are an array.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign in_bytes[b]            = in_data[8*(15-b) +: 8];
        // Gated so a partially substituted state never reaches the output.
        assign out_data[8*(15-b) +: 8] = out_valid_q ? st_q[b] : 8'h00;
    end

    // Lane l handles byte cnt*LANES + l of the current chunk.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = (cnt_q << LANE_SH) + 4'(l);
        assign lane_out[l] = sbox(st_q[lane_idx[l]]);
    end

    always_comb begin
        sub_bytes = st_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            sub_bytes[lane_idx[l]] = lane_out[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            st_q        <= '{default: 8'h00};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // in_ready is high whenever we are here out of reset.
                    if (in_valid) begin
                        st_q    <= in_bytes;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    st_q <= sub_bytes;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= 4'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gamma_serial.sv
// tb_gamma_serial: bench for gamma_serial. Five instances (LANES = 1,2,4,8,16)
// run against a transaction-level model: a block accepted while idle comes
// out 16/LANES edges later as the byte-wise S-box image of the whole block,
// and is held until taken.
module tb_gamma_serial;

    localparam int ND = 5;

    localparam logic [127:0] ZERO    = 128'h0;
    localparam logic [127:0] A7S     = {16{8'ha7}};
    localparam logic [127:0] FFS     = {16{8'hff}};
    localparam logic [127:0] S37     = {16{8'h37}};
    localparam logic [127:0] VEC_SEQ = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] VEC_SUB = 128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   in_data  [ND];
    logic [127:0]   out_data [ND];
    logic [ND-1:0]  in_valid, in_ready, out_valid, out_ready, busy;

    int total = 0;
    int bad   = 0;

    // Model state per instance.
    int           m_left [ND] = '{default: 0};
    bit           m_have [ND] = '{default: 1'b0};
    logic [127:0] m_res  [ND] = '{default: 128'h0};
    int           m_acc  [ND] = '{default: 0};

    // S-box rows: row r holds S(16r) .. S(16r+15), first entry in the top byte.
    logic [127:0] sb_rows [16] = '{
        128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd,
        128'h8ca57afb_63b8ddd4_e5b3c5be_a9880ca2,
        128'h39df29da_2ba8cb4c_4b22aa24_4170a6f9,
        128'h5ae2b036_7de433ff_6020088b_5eab7f78,
        128'h7c2c57d2_dc6d7e0d_5394c328_27065fad,
        128'h675c5548_0e52ea42_5b5d3058_51593c4e,
        128'h388a7214_e7c6de50_8e92d177_93459ace,
        128'h2d0362b6_b9bf966b_3f0712ae_4034463e,
        128'hdbcfeccc_c1a1c0d6_1df4613b_10d868a0,
        128'hb10a696c_49fa76c4_9e9b6e99_c2b798bc,
        128'h8f851fb4_f8112e00_251c2a3d_054f7bb2,
        128'h3290af19_a3f7739d_1574eeca_9f0f1b75,
        128'h86849c4a_971a65f6_ed09bb26_83eb6f81,
        128'h046a4301_17e187f5_8de32380_44166621,
        128'hfed531d9_35180264_f2f156cd_82c8baf0,
        128'hefe9e8fd_89d7c7b5_a42f9513_0bf3e037
    };

    function automatic logic [127:0] gamma(input logic [127:0] x);
        logic [127:0] r;
        logic [127:0] row;
        logic [7:0]   b;
        int           col;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b   = x[8*(15-k) +: 8];
            row = sb_rows[b[7:4]];
            col = int'(b[3:0]);
            r[8*(15-k) +: 8] = row[8*(15-col) +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int i, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", name, i, act, exp);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        gamma_serial #(
            .LANES(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .out_data (out_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .busy     (busy[g])
        );
    end

    always #5 clk = ~clk;

    // Model: inputs are driven on the falling edge, so they are stable here.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < ND; i++) begin
            if (rst) begin
                m_left[i] = 0;
                m_have[i] = 1'b0;
            end else if (m_have[i]) begin
                if (out_ready[i]) m_have[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) m_have[i] = 1'b1;
            end else if (in_valid[i]) begin
                m_left[i] = 16 >> i;
                m_res[i]  = gamma(in_data[i]);
                m_acc[i]++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("in_ready", i, 128'(in_ready[i]), 128'(!rst && !m_have[i] && m_left[i] == 0));
            chk("out_valid", i, 128'(out_valid[i]), 128'(m_have[i]));
            chk("busy", i, 128'(busy[i]), 128'(m_have[i] || m_left[i] != 0));
            if (m_have[i]) chk("out_data", i, out_data[i], m_res[i]);
        end
    end

    // Push one block through instance i and take the result.
    task automatic run_block(input int i, input logic [127:0] din, input logic [127:0] want,
                             input string name);
        int lat;
        in_data[i]  = din;
        in_valid[i] = 1'b1;
        @(negedge clk);
        in_valid[i] = 1'b0;
        lat = 0;
        while (!out_valid[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, i, 128'(lat), 128'(16 >> i));
        chk({name, "_data"}, i, out_data[i], want);
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk({name, "_taken"}, i, 128'(out_valid[i]), 128'(0));
    endtask

    initial begin
        int           lat;
        int           last_acc [ND];
        logic [127:0] blocks [4];

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < ND; i++) in_data[i] = '0;

        // Pin the model to hand-computed values.
        chk("model_zero", 0, gamma(ZERO), A7S);
        chk("model_seq", 0, gamma(VEC_SEQ), VEC_SUB);
        chk("model_ff", 0, gamma(FFS), S37);
        chk("model_invol", 0, gamma(VEC_SUB), VEC_SEQ);

        repeat (3) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk("rst_out_data", i, out_data[i], ZERO);
            chk("rst_out_valid", i, 128'(out_valid[i]), 128'(0));
            chk("rst_busy", i, 128'(busy[i]), 128'(0));
            chk("rst_in_ready", i, 128'(in_ready[i]), 128'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < ND; i++) chk("post_rst_in_ready", i, 128'(in_ready[i]), 128'(1));

        // Basic vectors on LANES=4, then forward and inverse on every width.
        run_block(2, ZERO, A7S, "zero");
        run_block(2, VEC_SEQ, VEC_SUB, "seq");
        for (int i = 0; i < ND; i++) begin
            run_block(i, VEC_SEQ, VEC_SUB, "fwd");
            run_block(i, VEC_SUB, VEC_SEQ, "inv");
        end

        // Backpressure: hold the result for 10 cycles while pulsing in_valid.
        in_data[2]  = ZERO;
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        lat = 0;
        while (!out_valid[2] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            in_data[2]  = FFS;
            in_valid[2] = c[0];
            chk("bp_out_valid", 2, 128'(out_valid[2]), 128'(1));
            chk("bp_out_data", 2, out_data[2], A7S);
            chk("bp_in_ready", 2, 128'(in_ready[2]), 128'(0));
            @(negedge clk);
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        @(negedge clk);
        chk("bp_no_accept_busy", 2, 128'(busy[2]), 128'(0));
        chk("bp_no_accept_valid", 2, 128'(out_valid[2]), 128'(0));

        // Reset two substitution edges into a block.
        in_data[2]  = VEC_SEQ;
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 2, 128'(busy[2]), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 2, 128'(out_valid[2]), 128'(0));
        chk("mid_rst_busy", 2, 128'(busy[2]), 128'(0));
        chk("mid_rst_in_ready", 2, 128'(in_ready[2]), 128'(0));
        chk("mid_rst_out_data", 2, out_data[2], ZERO);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 2, 128'(in_ready[2]), 128'(1));
        run_block(2, FFS, S37, "ff_after_rst");

        // Back-to-back with both handshakes held high on every instance.
        blocks[0] = VEC_SEQ;
        blocks[1] = FFS;
        blocks[2] = VEC_SUB;
        blocks[3] = 128'h0123456789abcdef_fedcba9876543210;
        for (int i = 0; i < ND; i++) last_acc[i] = -1;
        in_valid  = '1;
        out_ready = '1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            for (int i = 0; i < ND; i++) begin
                in_data[i] = blocks[m_acc[i] % 4];
                // in_ready here means acceptance on the coming edge.
                if (in_ready[i]) begin
                    if (last_acc[i] >= 0) begin
                        chk("b2b_spacing", i, 128'(cyc - last_acc[i]), 128'((16 >> i) + 2));
                    end
                    last_acc[i] = cyc;
                end
            end
            @(negedge clk);
        end
        in_valid = '0;
        repeat (20) @(negedge clk);
        out_ready = '0;
        for (int i = 0; i < ND; i++) chk("drained_busy", i, 128'(busy[i]), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
